// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI peripheral transceiver.
// FSM states: IDLE (no frame), SHIFT (bits moving), WORD_DONE (publish rx word).
package spi_slave_pkg;

    localparam int SPI_MAX_BITS = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SHIFT     = 2'd1,
        WORD_DONE = 2'd2
    } spi_state_t;

endpackage

// File: rtl/spi_input_synchronizer.sv
// Brings the asynchronous SPI pins into the system clock domain and derives
// edge strobes for SCLK and SS from one extra registered copy.
module spi_input_synchronizer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_sclk,
    input  logic i_ss,
    input  logic i_mosi,
    output logic o_ss,
    output logic o_mosi,
    output logic o_sclk_rise,
    output logic o_sclk_fall,
    output logic o_ss_rise,
    output logic o_ss_fall
);

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_ss_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_prev;
    logic                   r_ss_prev;

    logic w_sclk;

    // Chains reset to 0 so an SS already held low at reset release
    // never looks like a falling edge.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_sclk_sync <= '0;
            r_ss_sync   <= '0;
            r_mosi_sync <= '0;
            r_sclk_prev <= 1'b0;
            r_ss_prev   <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0],   i_ss};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
            r_sclk_prev <= r_sclk_sync[SYNC_STAGES-1];
            r_ss_prev   <= r_ss_sync[SYNC_STAGES-1];
        end
    end

    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign o_ss        = r_ss_sync[SYNC_STAGES-1];
    assign o_mosi      = r_mosi_sync[SYNC_STAGES-1];
    assign o_sclk_rise =  w_sclk & ~r_sclk_prev;
    assign o_sclk_fall = ~w_sclk &  r_sclk_prev;
    assign o_ss_rise   =  o_ss   & ~r_ss_prev;
    assign o_ss_fall   = ~o_ss   &  r_ss_prev;

endmodule

// File: rtl/spi_slave_transceiver.sv
// SPI peripheral: deserialises MOSI words and serialises a buffered tx word
// onto MISO, with run-time word length, CPOL/CPHA and bit order.
module spi_slave_transceiver
    import spi_slave_pkg::*;
#(
    parameter int N_BITS      = SPI_MAX_BITS,
    parameter int SYNC_STAGES = 2
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_spi_sclk,
    input  logic              i_spi_ss,
    input  logic              i_spi_mosi,
    output logic              o_spi_miso,
    input  logic [4:0]        i_cfg_word_length,
    input  logic              i_cfg_cpol,
    input  logic              i_cfg_cpha,
    input  logic              i_cfg_lsb_first,
    input  logic [N_BITS-1:0] i_tx_data,
    input  logic              i_tx_valid,
    output logic              o_tx_ready,
    output logic [N_BITS-1:0] o_rx_data,
    output logic              o_rx_valid,
    output logic              o_tx_underrun,
    output logic              o_busy
);

    spi_state_t        r_state;
    logic [4:0]        r_bit_cnt;
    logic [N_BITS-1:0] r_rx_shift;
    logic [N_BITS-1:0] r_tx_shift;
    logic [N_BITS-1:0] r_tx_buf;
    logic              r_tx_ready;
    logic              r_tx_primed;
    logic              r_spi_miso;
    logic [N_BITS-1:0] r_rx_data;
    logic              r_rx_valid;
    logic              r_tx_underrun;
    logic              r_busy;

    logic              w_ss;
    logic              w_mosi;
    logic              w_sclk_rise;
    logic              w_sclk_fall;
    logic              w_ss_rise;
    logic              w_ss_fall;
    logic              w_leading;
    logic              w_trailing;
    logic              w_sample;
    logic              w_drive;
    logic              w_drive_ok;
    logic              w_last;
    logic              w_word_start;
    logic              w_tx_accept;
    logic [N_BITS-1:0] w_tx_load;
    logic [N_BITS-1:0] w_tx_next;
    logic [N_BITS-1:0] w_rx_next;

    spi_input_synchronizer #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_sclk      (i_spi_sclk),
        .i_ss        (i_spi_ss),
        .i_mosi      (i_spi_mosi),
        .o_ss        (w_ss),
        .o_mosi      (w_mosi),
        .o_sclk_rise (w_sclk_rise),
        .o_sclk_fall (w_sclk_fall),
        .o_ss_rise   (w_ss_rise),
        .o_ss_fall   (w_ss_fall)
    );

    function automatic logic tx_head(input logic [N_BITS-1:0] v,
                                     input logic              lsb_first,
                                     input logic [4:0]        len_m1);
        return lsb_first ? v[0] : v[len_m1];
    endfunction

    assign w_leading  = i_cfg_cpol ? w_sclk_fall : w_sclk_rise;
    assign w_trailing = i_cfg_cpol ? w_sclk_rise : w_sclk_fall;
    assign w_sample   = i_cfg_cpha ? w_trailing  : w_leading;
    assign w_drive    = i_cfg_cpha ? w_leading   : w_trailing;

    // With cpha=0 a trailing edge seen before any sample of the current word
    // is the tail of the previous word, not a request for the next bit.
    assign w_drive_ok = w_drive && (i_cfg_cpha || (r_bit_cnt != 5'd0));
    assign w_last     = (r_bit_cnt == i_cfg_word_length);

    assign w_word_start = ((r_state == IDLE) && w_ss_fall) ||
                          ((r_state == WORD_DONE) && !w_ss);
    assign w_tx_accept  = i_tx_valid && r_tx_ready;
    assign w_tx_load    = r_tx_ready ? '0 : r_tx_buf;
    assign w_tx_next    = i_cfg_lsb_first ? (r_tx_shift >> 1) : (r_tx_shift << 1);

    always_comb begin
        w_rx_next = '0;
        if (i_cfg_lsb_first) begin
            w_rx_next = r_rx_shift >> 1;
            w_rx_next[i_cfg_word_length] = w_mosi;
        end else begin
            w_rx_next = {r_rx_shift[N_BITS-2:0], w_mosi};
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state       <= IDLE;
            r_bit_cnt     <= '0;
            r_rx_shift    <= '0;
            r_tx_shift    <= '0;
            r_tx_buf      <= '0;
            r_tx_ready    <= 1'b1;
            r_tx_primed   <= 1'b0;
            r_spi_miso    <= 1'b0;
            r_rx_data     <= '0;
            r_rx_valid    <= 1'b0;
            r_tx_underrun <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_rx_valid    <= 1'b0;
            r_tx_underrun <= 1'b0;

            if (w_tx_accept) begin
                r_tx_buf   <= i_tx_data;
                r_tx_ready <= 1'b0;
            end

            if (w_word_start) begin
                r_state     <= SHIFT;
                r_busy      <= 1'b1;
                r_bit_cnt   <= '0;
                r_rx_shift  <= '0;
                r_tx_shift  <= w_tx_load;
                r_tx_primed <= !i_cfg_cpha;
                r_spi_miso  <= i_cfg_cpha ? 1'b0 :
                               tx_head(w_tx_load, i_cfg_lsb_first, i_cfg_word_length);
                // Empty buffer underruns; data arriving this cycle waits for the next word.
                if (r_tx_ready) begin
                    r_tx_underrun <= 1'b1;
                    r_tx_ready    <= !w_tx_accept;
                end else begin
                    r_tx_ready    <= 1'b1;
                end
            end else begin
                case (r_state)
                    IDLE: begin
                        r_spi_miso <= 1'b0;
                    end
                    SHIFT: begin
                        if (w_sample && w_last) begin
                            r_state    <= WORD_DONE;
                            r_rx_data  <= w_rx_next;
                            r_rx_valid <= 1'b1;
                            r_bit_cnt  <= '0;
                        end else if (w_ss_rise) begin
                            r_state    <= IDLE;
                            r_busy     <= 1'b0;
                            r_spi_miso <= 1'b0;
                        end else begin
                            if (w_sample) begin
                                r_rx_shift <= w_rx_next;
                                r_bit_cnt  <= r_bit_cnt + 5'd1;
                            end
                            if (w_drive_ok) begin
                                if (r_tx_primed) begin
                                    r_tx_shift <= w_tx_next;
                                    r_spi_miso <= tx_head(w_tx_next, i_cfg_lsb_first,
                                                          i_cfg_word_length);
                                end else begin
                                    r_spi_miso  <= tx_head(r_tx_shift, i_cfg_lsb_first,
                                                           i_cfg_word_length);
                                    r_tx_primed <= 1'b1;
                                end
                            end
                        end
                    end
                    WORD_DONE: begin
                        r_state    <= IDLE;
                        r_busy     <= 1'b0;
                        r_spi_miso <= 1'b0;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign o_spi_miso    = r_spi_miso;
    assign o_tx_ready    = r_tx_ready;
    assign o_rx_data     = r_rx_data;
    assign o_rx_valid    = r_rx_valid;
    assign o_tx_underrun = r_tx_underrun;
    assign o_busy        = r_busy;

endmodule
